// File: rtl/half_adder_dataflow_18ec068.sv
// Lane-parallel half adder with combinational sum/carry, a one-cycle registered
// copy qualified by a valid flag, and a saturating count of carrying cycles.
module half_adder_dataflow_18ec068 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s_q,
  output logic [WIDTH-1:0] c_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Lanes are independent: no carry ripples between bit positions.
  assign s = a ^ b;
  assign c = a & b;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q         <= '0;
      c_q         <= '0;
      out_valid   <= 1'b0;
      carry_count <= '0;
    end else begin
      // Result registers hold on idle cycles; only out_valid drops.
      if (in_valid) begin
        s_q <= s;
        c_q <= c;
      end
      out_valid <= in_valid;
      if (in_valid && (|c) && (carry_count != CNT_MAX))
        carry_count <= carry_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_half_adder_dataflow_18ec068.sv
// Self-checking bench: three configurations of the half adder, with expected
// registered results queued at drive time and compared after the capturing edge.
module tb_half_adder_dataflow_18ec068;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=1, CNT_W=8
  logic [0:0] a1 = '0, b1 = '0, s1, c1, sq1, cq1;
  logic       iv1 = 1'b0, ov1;
  logic [7:0] cnt1;
  // WIDTH=4, CNT_W=2
  logic [3:0] a4 = '0, b4 = '0, s4, c4, sq4, cq4;
  logic       iv4 = 1'b0, ov4;
  logic [1:0] cnt4;
  // WIDTH=8, CNT_W=8
  logic [7:0] a8 = '0, b8 = '0, s8, c8, sq8, cq8;
  logic       iv8 = 1'b0, ov8;
  logic [7:0] cnt8;

  half_adder_dataflow_18ec068 #(.WIDTH(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(iv1), .s(s1), .c(c1),
    .s_q(sq1), .c_q(cq1), .out_valid(ov1), .carry_count(cnt1));
  half_adder_dataflow_18ec068 #(.WIDTH(4), .CNT_W(2)) u4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(iv4), .s(s4), .c(c4),
    .s_q(sq4), .c_q(cq4), .out_valid(ov4), .carry_count(cnt4));
  half_adder_dataflow_18ec068 #(.WIDTH(8), .CNT_W(8)) u8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(iv8), .s(s8), .c(c8),
    .s_q(sq8), .c_q(cq8), .out_valid(ov8), .carry_count(cnt8));

  typedef struct packed {
    logic [7:0] s_q;
    logic [7:0] c_q;
    logic       ov;
    logic [7:0] cnt;
  } exp_t;

  exp_t scb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t obs1();
    return exp_t'{8'(sq1), 8'(cq1), ov1, cnt1};
  endfunction
  function automatic exp_t obs4();
    return exp_t'{8'(sq4), 8'(cq4), ov4, 8'(cnt4)};
  endfunction
  function automatic exp_t obs8();
    return exp_t'{sq8, cq8, ov8, cnt8};
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t zero = '0;
    #1;
    checks++;
    if (obs1() !== zero) begin
      errors++;
      $display("FAIL reset_u1 got %h want %h", obs1(), zero);
    end
    checks++;
    if (obs4() !== zero) begin
      errors++;
      $display("FAIL reset_u4 got %h want %h", obs4(), zero);
    end
    checks++;
    if (obs8() !== zero) begin
      errors++;
      $display("FAIL reset_u8 got %h want %h", obs8(), zero);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_comb_sweep();
    logic [3:0] tbl_s = 4'b0110;
    logic [3:0] tbl_c = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = 2'(i);
      #10;
      checks++;
      if ({s1, c1} !== {tbl_s[i], tbl_c[i]}) begin
        errors++;
        $display("FAIL comb_ab%0d got s=%b c=%b want s=%b c=%b", i, s1, c1, tbl_s[i], tbl_c[i]);
      end
      #40;
    end
  endtask

  task automatic test_registered();
    exp_t e;
    scb.delete();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
    scb.push_back(exp_t'{8'd0, 8'd1, 1'b1, 8'd1});
    @(negedge clk);
    e = scb.pop_front();
    checks++;
    if (obs1() !== e) begin
      errors++;
      $display("FAIL reg_capture got %h want %h", obs1(), e);
    end
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
    scb.push_back(exp_t'{8'd0, 8'd1, 1'b0, 8'd1});
    @(negedge clk);
    e = scb.pop_front();
    checks++;
    if (obs1() !== e) begin
      errors++;
      $display("FAIL reg_hold got %h want %h", obs1(), e);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    exp_t zero = '0;
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs1() !== zero) begin
      errors++;
      $display("FAIL async_reset got %h want %h", obs1(), zero);
    end
    a1 = 1'b1; b1 = 1'b0;
    #1;
    checks++;
    if ({s1, c1} !== 2'b10) begin
      errors++;
      $display("FAIL comb_in_reset got s=%b c=%b want s=1 c=0", s1, c1);
    end
    @(negedge clk);
    rst = 1'b0;
    a1 = 1'b0; b1 = 1'b1; iv1 = 1'b1;
    scb.delete();
    scb.push_back(exp_t'{8'd1, 8'd0, 1'b1, 8'd0});
    @(negedge clk);
    iv1 = 1'b0;
    e = scb.pop_front();
    checks++;
    if (obs1() !== e) begin
      errors++;
      $display("FAIL first_after_reset got %h want %h", obs1(), e);
    end
  endtask

  task automatic test_counter();
    logic [3:0] va [3] = '{4'b1010, 4'b0101, 4'hF};
    logic [3:0] vb [3] = '{4'b0110, 4'b1010, 4'h1};
    logic [7:0] vcnt [3] = '{8'd1, 8'd1, 8'd2};
    exp_t e;
    scb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (scb.size() > 0) begin
        e = scb.pop_front();
        checks++;
        if (obs4() !== e) begin
          errors++;
          $display("FAIL counter_v%0d got %h want %h", i - 1, obs4(), e);
        end
      end
      a4 = va[i]; b4 = vb[i]; iv4 = 1'b1;
      scb.push_back(exp_t'{8'(va[i] ^ vb[i]), 8'(va[i] & vb[i]), 1'b1, vcnt[i]});
      #1;
      if (i == 0) begin
        checks++;
        if (s4 !== 4'b1100) begin
          errors++;
          $display("FAIL counter_s0 got %b want 1100", s4);
        end
      end
      if (i == 2) begin
        checks++;
        if (c4 !== 4'b0001) begin
          errors++;
          $display("FAIL counter_c2 got %b want 0001", c4);
        end
      end
    end
    @(negedge clk);
    iv4 = 1'b0;
    e = scb.pop_front();
    checks++;
    if (obs4() !== e) begin
      errors++;
      $display("FAIL counter_v2 got %h want %h", obs4(), e);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] vcnt [5] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
    exp_t e;
    pulse_reset();
    scb.delete();
    a4 = 4'hF; b4 = 4'hF;
    for (int i = 0; i < 5; i++) begin
      iv4 = 1'b1;
      scb.push_back(exp_t'{8'h00, 8'h0F, 1'b1, vcnt[i]});
      @(negedge clk);
      e = scb.pop_front();
      checks++;
      if (obs4() !== e) begin
        errors++;
        $display("FAIL saturate_%0d got %h want %h", i, obs4(), e);
      end
    end
    iv4 = 1'b0;
  endtask

  task automatic test_random();
    exp_t m = '0;
    exp_t e;
    int   bad = 0;
    pulse_reset();
    scb.delete();
    for (int i = 0; i < 1000; i++) begin
      if (scb.size() > 0) begin
        e = scb.pop_front();
        checks++;
        if (obs8() !== e) begin
          errors++;
          if (bad++ < 10) $display("FAIL random_reg_%0d got %h want %h", i, obs8(), e);
        end
      end
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      iv8 = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if ({s8, c8} !== {a8 ^ b8, a8 & b8}) begin
        errors++;
        if (bad++ < 10) $display("FAIL random_comb_%0d got s=%h c=%h want s=%h c=%h", i, s8, c8, a8 ^ b8, a8 & b8);
      end
      if (iv8) begin
        m.s_q = a8 ^ b8;
        m.c_q = a8 & b8;
        if ((|(a8 & b8)) && m.cnt != 8'hFF) m.cnt = m.cnt + 8'd1;
      end
      m.ov = iv8;
      scb.push_back(m);
      @(negedge clk);
    end
    iv8 = 1'b0;
    e = scb.pop_front();
    checks++;
    if (obs8() !== e) begin
      errors++;
      $display("FAIL random_last got %h want %h", obs8(), e);
    end
  endtask

  initial begin
    test_reset();
    test_comb_sweep();
    test_registered();
    test_async_reset();
    test_counter();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/half_adder_dataflow_18ec068.md
Name: half_adder_dataflow_18ec068

Overview:
- Lane-parallel half adder. Each lane i computes sum = a[i] XOR b[i] and carry = a[i] AND b[i].
- Provides combinational outputs, plus a one-cycle registered copy with a valid flag and a saturating carry-event counter.
- Sits as a leaf arithmetic primitive. Used directly by datapaths and as the building block of ripple adders and the status logic of higher blocks.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (>=1).
- CNT_W, 8, width of the carry-event counter (>=1).

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  addend A, one bit per lane.
- b  input  WIDTH  addend B, one bit per lane.
- in_valid  input  1  qualifies a/b for the registered path and the counter.
- s  output  WIDTH  combinational sum, a ^ b.
- c  output  WIDTH  combinational carry, a & b.
- s_q  output  WIDTH  registered sum.
- c_q  output  WIDTH  registered carry.
- out_valid  output  1  s_q/c_q hold a result captured from a valid input.
- carry_count  output  CNT_W  number of valid cycles in which any lane carried; saturates at the maximum.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high (rst).
- Combinational path:
  - s = a ^ b and c = a & b, bitwise per lane, zero latency.
  - No dependence on clk, rst or in_valid.
  - Lanes are fully independent; there is no carry propagation between lanes.
  - Truth table per lane (a,b -> s,c): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
- Reset:
  - While rst = 1, immediately (no clock needed): s_q = 0, c_q = 0, out_valid = 0, carry_count = 0.
  - Combinational s/c keep following a/b during reset.
- Registered path, each rising clk edge with rst = 0:
  - If in_valid = 1: s_q <= a ^ b, c_q <= a & b, out_valid <= 1.
  - If in_valid = 0: out_valid <= 0; s_q and c_q hold their previous values.
  - Latency is exactly 1 cycle from valid input to out_valid and s_q/c_q.
  - Back-to-back valid inputs are accepted every cycle; there is no backpressure.
- Carry counter, each rising clk edge with rst = 0:
  - If in_valid = 1, any bit of (a & b) = 1, and carry_count < 2^CNT_W - 1, increment by 1.
  - At all-ones the counter holds (saturates); it never wraps.
  - Only a reset clears it.
- Reset mid-operation:
  - Asserting rst between edges clears all registers at once.
  - The first valid input after deassertion is captured on the next edge with normal 1-cycle latency.
- X handling: the block adds no X generation; X on a/b propagates to s/c as per the operators.
- No internal state machine beyond the registers above.

Test Plan:
- WIDTH=1, comb sweep, 50 ns per vector: (a,b) = 00, 01, 10, 11 -> (s,c) = (0,0), (1,0), (1,0), (0,1). Outputs settle within the step, independent of clk.
- Registered path: in_valid=1 with a=1, b=1 at one edge -> after that edge s_q=0, c_q=1, out_valid=1. Next edge with in_valid=0 -> out_valid=0, s_q=0 and c_q=1 held.
- Reset: rst=1 asynchronously after a valid capture, between edges -> s_q=0, c_q=0, out_valid=0, carry_count=0 immediately, while s/c still track a/b.
- Counter: WIDTH=4, valid inputs a=4'b1010,b=4'b0110 (carry), then a=4'b0101,b=4'b1010 (no carry), then a=4'hF,b=4'h1 (carry) -> carry_count = 1, 1, 2. s for the first vector = 4'b1100; c for the third = 4'b0001.
- Saturation: CNT_W=2, five consecutive valid carrying inputs -> carry_count = 1, 2, 3, 3, 3.
- Random: 1000 cycles of random a, b and in_valid with WIDTH=8, checked against a reference model of s, c, s_q, c_q, out_valid and carry_count.
